// File: rtl/mshr_repair_engine_pkg.sv
// Shared types for the MSHR repair engine.
//   ROB_ENTRIES    : reorder buffer depth; sets the ROB index width
//   rob_idx_t      : ROB index
//   repair_state_e : repair FSM states
//   repair_req_t   : repair request captured at ack time
package mshr_repair_engine_pkg;

  localparam int unsigned ROB_ENTRIES = 32;

  typedef logic [$clog2(ROB_ENTRIES)-1:0] rob_idx_t;

  typedef enum logic [2:0] {
    StIdle,
    StMemReq,
    StMemWait,
    StFill,
    StWb,
    StDone
  } repair_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;     // store data; replaced by read data once a load response arrives
    rob_idx_t    rob_idx;
    logic        is_store;
  } repair_req_t;

endpackage

// File: rtl/mshr_repair_engine_if.sv
// Bundle of every handshake/bus signal around the repair engine.
//   repair_* : MSHR request, ack and completion
//   mem_*    : next-level memory request and response
//   fill_*   : L1D fill strobe
//   wb_*     : ROB writeback
//   err_timeout : sticky memory timeout flag
// Modport slave is the engine side; modport master is the surrounding environment.
interface mshr_repair_engine_if
  import mshr_repair_engine_pkg::*;
#(
  parameter int unsigned ROB_IDX_W = $clog2(ROB_ENTRIES)
) ();

  logic                 repair_req;
  logic [31:0]          repair_req_addr;
  logic [31:0]          repair_req_data;
  logic [ROB_IDX_W-1:0] repair_req_rob_idx;
  logic                 repair_is_store;
  logic                 repair_ack;
  logic                 repair_complete;

  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic                 mem_req_we;
  logic [31:0]          mem_req_addr;
  logic [31:0]          mem_req_wdata;
  logic                 mem_resp_valid;
  logic [31:0]          mem_resp_data;

  logic                 fill_valid;
  logic [31:0]          fill_addr;
  logic [31:0]          fill_data;

  logic                 wb_valid;
  logic                 wb_ready;
  logic [ROB_IDX_W-1:0] wb_rob_idx;
  logic [31:0]          wb_data;

  logic                 err_timeout;

  modport slave (
    input  repair_req, repair_req_addr, repair_req_data, repair_req_rob_idx, repair_is_store,
    output repair_ack, repair_complete,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output fill_valid, fill_addr, fill_data,
    output wb_valid, wb_rob_idx, wb_data,
    input  wb_ready,
    output err_timeout
  );

  modport master (
    output repair_req, repair_req_addr, repair_req_data, repair_req_rob_idx, repair_is_store,
    input  repair_ack, repair_complete,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  fill_valid, fill_addr, fill_data,
    input  wb_valid, wb_rob_idx, wb_data,
    output wb_ready,
    input  err_timeout
  );

endinterface

// File: rtl/mshr_repair_engine.sv
// Responder end of the MSHR repair interface. Takes one repair at a time, issues it to the next
// memory level, fills the L1D, writes load data back to the ROB and pulses repair_complete.
// Ports:
//   clk   : core clock
//   rst_n : asynchronous active-low reset
//   bus   : mshr_repair_engine_if.slave (MSHR request, memory, fill, writeback, err_timeout)
// Parameters:
//   MEM_TIMEOUT : cycles allowed in the memory wait before the repair is aborted (>= 2)
//   ROB_IDX_W   : ROB index width
module mshr_repair_engine
  import mshr_repair_engine_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 1024,
  parameter int unsigned ROB_IDX_W   = $clog2(ROB_ENTRIES)
) (
  input logic                 clk,
  input logic                 rst_n,
  mshr_repair_engine_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(MEM_TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  repair_state_e        state_q;
  repair_req_t          req_q;
  logic [CntW-1:0]      cnt_q;

  logic                 mem_req_valid_q;
  logic                 mem_req_we_q;
  logic [31:0]          mem_req_addr_q;
  logic [31:0]          mem_req_wdata_q;
  logic                 fill_valid_q;
  logic [31:0]          fill_addr_q;
  logic [31:0]          fill_data_q;
  logic                 wb_valid_q;
  logic [ROB_IDX_W-1:0] wb_rob_idx_q;
  logic [31:0]          wb_data_q;
  logic                 complete_q;
  logic                 err_timeout_q;

  // Ack is the only combinational output; gated by reset so every output reads 0 under reset.
  assign bus.repair_ack      = rst_n && (state_q == StIdle) && bus.repair_req;
  assign bus.repair_complete = complete_q;
  assign bus.mem_req_valid   = mem_req_valid_q;
  assign bus.mem_req_we      = mem_req_we_q;
  assign bus.mem_req_addr    = mem_req_addr_q;
  assign bus.mem_req_wdata   = mem_req_wdata_q;
  assign bus.fill_valid      = fill_valid_q;
  assign bus.fill_addr       = fill_addr_q;
  assign bus.fill_data       = fill_data_q;
  assign bus.wb_valid        = wb_valid_q;
  assign bus.wb_rob_idx      = wb_rob_idx_q;
  assign bus.wb_data         = wb_data_q;
  assign bus.err_timeout     = err_timeout_q;

  // Outputs are registered: each is set on the transition into the state that presents it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      req_q           <= '0;
      cnt_q           <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_we_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
      fill_valid_q    <= 1'b0;
      fill_addr_q     <= '0;
      fill_data_q     <= '0;
      wb_valid_q      <= 1'b0;
      wb_rob_idx_q    <= '0;
      wb_data_q       <= '0;
      complete_q      <= 1'b0;
      err_timeout_q   <= 1'b0;
    end else begin
      fill_valid_q <= 1'b0;
      complete_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.repair_req) begin
            req_q.addr      <= bus.repair_req_addr;
            req_q.data      <= bus.repair_req_data;
            req_q.rob_idx   <= rob_idx_t'(bus.repair_req_rob_idx);
            req_q.is_store  <= bus.repair_is_store;
            mem_req_valid_q <= 1'b1;
            mem_req_we_q    <= bus.repair_is_store;
            mem_req_addr_q  <= bus.repair_req_addr;
            mem_req_wdata_q <= bus.repair_req_data;
            state_q         <= StMemReq;
          end
        end
        StMemReq: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            cnt_q           <= '0;
            state_q         <= StMemWait;
          end
        end
        StMemWait: begin
          cnt_q <= cnt_q + 1'b1;
          // A response arriving on the last allowed cycle still beats the timeout.
          if (bus.mem_resp_valid) begin
            if (!req_q.is_store) begin
              req_q.data <= bus.mem_resp_data;
            end
            fill_valid_q <= 1'b1;
            fill_addr_q  <= req_q.addr;
            fill_data_q  <= req_q.is_store ? req_q.data : bus.mem_resp_data;
            state_q      <= StFill;
          end else if (cnt_q == CntLast) begin
            err_timeout_q <= 1'b1;
            complete_q    <= 1'b1;
            state_q       <= StDone;
          end
        end
        StFill: begin
          if (req_q.is_store) begin
            complete_q <= 1'b1;
            state_q    <= StDone;
          end else begin
            wb_valid_q   <= 1'b1;
            wb_rob_idx_q <= ROB_IDX_W'(req_q.rob_idx);
            wb_data_q    <= req_q.data;
            state_q      <= StWb;
          end
        end
        StWb: begin
          if (bus.wb_ready) begin
            wb_valid_q <= 1'b0;
            complete_q <= 1'b1;
            state_q    <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mshr_repair_engine.sv
// Scoreboard bench for mshr_repair_engine. The stimulus process plays each repair on a fixed
// schedule (ack cycle, memory ready delay, response latency, writeback ready delay) and pushes the
// expected events with their cycle stamps; the monitor pops and compares whenever the DUT shows one.
module tb_mshr_repair_engine;
  import mshr_repair_engine_pkg::*;

  localparam int unsigned T  = 8;
  localparam int unsigned RW = $clog2(ROB_ENTRIES);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  bit   err_model = 1'b0;

  mshr_repair_engine_if #(.ROB_IDX_W(RW)) bus ();

  mshr_repair_engine #(
    .MEM_TIMEOUT(T),
    .ROB_IDX_W  (RW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]   addr;
    logic [31:0]   data;
    logic [31:0]   rdata;
    logic [RW-1:0] rob;
    bit            st;
    int            rd;   // cycles mem_req_ready is held low
    int            lat;  // response latency in wait cycles; >= T means no response
    int            wd;   // cycles wb_ready is held low
  } txn_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          we;
  } mreq_t;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  int    ack_q[$];
  mreq_t mreq_q[$];
  ev_t   fill_q[$];
  ev_t   wb_q[$];
  ev_t   cpl_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic outs_any();
    return |{bus.repair_ack, bus.repair_complete, bus.mem_req_valid, bus.mem_req_we,
             bus.mem_req_addr, bus.mem_req_wdata, bus.fill_valid, bus.fill_addr, bus.fill_data,
             bus.wb_valid, bus.wb_rob_idx, bus.wb_data, bus.err_timeout};
  endfunction

  function automatic txn_t mk(input logic [31:0] addr, input logic [31:0] data,
                              input logic [31:0] rdata, input int rob, input bit st,
                              input int rd, input int lat, input int wd);
    txn_t t;
    t.addr = addr; t.data = data; t.rdata = rdata; t.rob = RW'(rob); t.st = st;
    t.rd = rd; t.lat = lat; t.wd = wd;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    return mk($urandom, $urandom, $urandom, int'($urandom_range(ROB_ENTRIES - 1, 0)),
              bit'($urandom_range(1, 0)), int'($urandom_range(3, 0)),
              int'($urandom_range(T + 1, 0)), int'($urandom_range(3, 0)));
  endfunction

  // Caller guarantees the engine is idle in the current cycle.
  task automatic run_txn(input txn_t t, input bit hold);
    int    a, resp_c, wait_hi, d;
    bit    to;
    mreq_t m;
    ev_t   e;
    a       = cyc;
    to      = (t.lat >= T);
    resp_c  = a + 2 + t.rd + t.lat;
    wait_hi = to ? a + 1 + t.rd + T : resp_c;
    if (to)        d = a + 2 + t.rd + T;
    else if (t.st) d = resp_c + 2;
    else           d = resp_c + 3 + t.wd;
    if (to) err_model = 1'b1;
    ack_q.push_back(a);
    m.addr = t.addr; m.wdata = t.data; m.we = t.st;
    mreq_q.push_back(m);
    if (!to) begin
      e.cyc = resp_c + 1; e.a = t.addr; e.d = t.st ? t.data : t.rdata;
      fill_q.push_back(e);
    end
    if (!to && !t.st) begin
      e.cyc = resp_c + 2 + t.wd; e.a = 32'(t.rob); e.d = t.rdata;
      wb_q.push_back(e);
    end
    e.cyc = d; e.a = {31'd0, err_model}; e.d = 32'd0;
    cpl_q.push_back(e);
    for (int c = a; c <= d; c++) begin
      bus.repair_req = (c == a) || hold;
      if (c == a) begin
        bus.repair_req_addr    = t.addr;
        bus.repair_req_data    = t.data;
        bus.repair_req_rob_idx = t.rob;
        bus.repair_is_store    = t.st;
      end else begin
        bus.repair_req_addr    = $urandom;
        bus.repair_req_data    = $urandom;
        bus.repair_req_rob_idx = RW'($urandom);
        bus.repair_is_store    = 1'($urandom);
      end
      bus.mem_req_ready = (c >= a + 1 + t.rd);
      if (!to && c == resp_c) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = t.rdata;
      end else begin
        // Stray responses only outside the wait window; the engine must ignore them.
        bus.mem_resp_valid = (c < a + 2 + t.rd || c > wait_hi) && ($urandom_range(3, 0) == 0);
        bus.mem_resp_data  = $urandom;
      end
      bus.wb_ready = (c >= resp_c + 2 + t.wd);
      @(posedge clk); #1;
    end
    bus.repair_req     = hold;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.wb_ready       = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.repair_req     = 1'b0;
      bus.mem_req_ready  = 1'($urandom);
      bus.mem_resp_valid = ($urandom_range(3, 0) == 0);
      bus.mem_resp_data  = $urandom;
      bus.wb_ready       = 1'($urandom);
      @(posedge clk); #1;
    end
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.wb_ready       = 1'b0;
  endtask

  // Monitor: compares every DUT event against the front of its expectation queue.
  ev_t   me;
  mreq_t mm;
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack_q.size() != 0 && ack_q[0] < cyc) chk("ack_missing", cyc, ack_q.pop_front());
      if (fill_q.size() != 0 && fill_q[0].cyc < cyc) begin
        me = fill_q.pop_front(); chk("fill_missing", cyc, me.cyc);
      end
      if (wb_q.size() != 0 && wb_q[0].cyc < cyc) begin
        me = wb_q.pop_front(); chk("wb_missing", cyc, me.cyc);
      end
      if (cpl_q.size() != 0 && cpl_q[0].cyc < cyc) begin
        me = cpl_q.pop_front(); chk("complete_missing", cyc, me.cyc);
      end

      if (bus.repair_ack) begin
        if (ack_q.size() != 0) chk("ack_cycle", cyc, ack_q.pop_front());
        else                   chk("ack_unexpected", bus.repair_ack, 0);
      end

      if (bus.mem_req_valid) begin
        if (mreq_q.size() != 0) begin
          mm = mreq_q[0];
          chk("mem_req_addr", bus.mem_req_addr, mm.addr);
          chk("mem_req_we", bus.mem_req_we, mm.we);
          if (mm.we) chk("mem_req_wdata", bus.mem_req_wdata, mm.wdata);
          if (bus.mem_req_ready) void'(mreq_q.pop_front());
        end else begin
          chk("mem_req_unexpected", bus.mem_req_valid, 0);
        end
      end

      if (bus.fill_valid) begin
        if (fill_q.size() != 0) begin
          me = fill_q.pop_front();
          chk("fill_cycle", cyc, me.cyc);
          chk("fill_addr", bus.fill_addr, me.a);
          chk("fill_data", bus.fill_data, me.d);
        end else begin
          chk("fill_unexpected", bus.fill_valid, 0);
        end
      end

      if (bus.wb_valid) begin
        if (wb_q.size() != 0) begin
          chk("wb_rob_idx", bus.wb_rob_idx, wb_q[0].a);
          chk("wb_data", bus.wb_data, wb_q[0].d);
          if (bus.wb_ready) begin
            me = wb_q.pop_front();
            chk("wb_cycle", cyc, me.cyc);
          end
        end else begin
          chk("wb_unexpected", bus.wb_valid, 0);
        end
      end

      if (bus.repair_complete) begin
        chk("complete_with_ack", bus.repair_ack, 0);
        if (cpl_q.size() != 0) begin
          me = cpl_q.pop_front();
          chk("complete_cycle", cyc, me.cyc);
          chk("err_timeout", bus.err_timeout, me.a);
        end else begin
          chk("complete_unexpected", bus.repair_complete, 0);
        end
      end
    end
  end

  initial begin
    bus.repair_req         = 1'b0;
    bus.repair_req_addr    = '0;
    bus.repair_req_data    = '0;
    bus.repair_req_rob_idx = '0;
    bus.repair_is_store    = 1'b0;
    bus.mem_req_ready      = 1'b0;
    bus.mem_resp_valid     = 1'b0;
    bus.mem_resp_data      = '0;
    bus.wb_ready           = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs_any(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Zero-wait load, store, backpressured load.
    run_txn(mk(32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 5, 1'b0, 0, 0, 0), 1'b0);
    idle(1);
    run_txn(mk(32'h0000_2004, 32'h1234_5678, 32'hCAFE_F00D, 3, 1'b1, 0, 0, 0), 1'b0);
    idle(1);
    run_txn(mk(32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 5, 1'b0, 3, 0, 2), 1'b0);
    idle(1);

    // Timeout, then response exactly on the last allowed wait cycle with the flag still set.
    run_txn(mk(32'h0000_3000, 32'h0, 32'h1111_2222, 7, 1'b0, 0, T, 0), 1'b0);
    idle(1);
    run_txn(mk(32'h0000_3004, 32'h0, 32'h3333_4444, 8, 1'b0, 0, T - 1, 0), 1'b0);
    idle(1);

    // Back-to-back with repair_req held high.
    run_txn(mk(32'h0000_4000, 32'h0, 32'h5555_6666, 1, 1'b0, 0, 0, 0), 1'b1);
    run_txn(mk(32'h0000_4040, 32'h0, 32'h7777_8888, 2, 1'b0, 0, 0, 0), 1'b0);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      run_txn(rnd_txn(), bit'($urandom_range(3, 0) == 0));
      if (!bus.repair_req) idle(int'($urandom_range(2, 0)));
    end
    idle(1);

    // Make sure the sticky flag is set before the reset scenario.
    run_txn(mk(32'h0000_5000, 32'h0, 32'h0, 4, 1'b0, 1, T + 1, 0), 1'b0);
    idle(1);

    // Reset while waiting for memory, then a stray response.
    begin
      mreq_t m;
      int    a;
      a = cyc;
      bus.repair_req         = 1'b1;
      bus.repair_req_addr    = 32'h0000_6000;
      bus.repair_req_data    = 32'h0;
      bus.repair_req_rob_idx = RW'(9);
      bus.repair_is_store    = 1'b0;
      bus.mem_req_ready      = 1'b1;
      ack_q.push_back(a);
      m.addr = 32'h0000_6000; m.wdata = 32'h0; m.we = 1'b0;
      mreq_q.push_back(m);
      @(posedge clk); #1;
      bus.repair_req = 1'b0;
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b0;
      rst_n     = 1'b0;
      err_model = 1'b0;
      @(negedge clk);
      chk("reset_mid_repair_outputs", outs_any(), 0);
      @(posedge clk); #1;
      rst_n              = 1'b1;
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'hBAD0_BAD0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("after_reset_outputs", outs_any(), 0);
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b0;
      end
    end

    // Engine still works after reset, with the timeout flag cleared.
    run_txn(mk(32'h0000_7000, 32'h0, 32'hABCD_0123, 6, 1'b0, 0, 2, 1), 1'b0);
    idle(4);

    chk("queues_drained",
        ack_q.size() + mreq_q.size() + fill_q.size() + wb_q.size() + cpl_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
